// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its neighbours.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: downstream control, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(parameter int WIDTH = 32);

  logic             stall_in;
  logic             flush_in;
  logic             redirect_valid_in;
  logic [WIDTH-1:0] redirect_pc_in;
  logic [WIDTH-3:0] imem_addr_out;
  logic [WIDTH-1:0] imem_data_in;
  logic             if_id_valid_out;
  logic [WIDTH-1:0] if_id_pc_out;
  logic [WIDTH-1:0] if_id_pc_plus4_out;
  logic [WIDTH-1:0] if_id_instr_out;
  logic             fault_out;
  logic [WIDTH-1:0] fault_pc_out;

  modport master (
    input  stall_in, flush_in, redirect_valid_in, redirect_pc_in, imem_data_in,
    output imem_addr_out, if_id_valid_out, if_id_pc_out, if_id_pc_plus4_out,
           if_id_instr_out, fault_out, fault_pc_out
  );

  modport slave (
    output stall_in, flush_in, redirect_valid_in, redirect_pc_in, imem_data_in,
    input  imem_addr_out, if_id_valid_out, if_id_pc_out, if_id_pc_plus4_out,
           if_id_instr_out, fault_out, fault_pc_out
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register; bubble wins over load, otherwise contents hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [WIDTH-1:0] d_pc_plus4,
  input  logic [WIDTH-1:0] d_instr,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_pc,
  output logic [WIDTH-1:0] q_pc_plus4,
  output logic [WIDTH-1:0] q_instr
);

  logic             valid_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] pc_plus4_r;
  logic [WIDTH-1:0] instr_r;

  // Pipeline register update: reset/bubble, load, or hold
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_r    <= 1'b0;
      pc_r       <= {WIDTH{1'b0}};
      pc_plus4_r <= {WIDTH{1'b0}};
      instr_r    <= WIDTH'(NOP_INSTR);
    end else if (load) begin
      valid_r    <= 1'b1;
      pc_r       <= d_pc;
      pc_plus4_r <= d_pc_plus4;
      instr_r    <= d_instr;
    end
  end

  assign q_valid    = valid_r;
  assign q_pc       = pc_r;
  assign q_pc_plus4 = pc_plus4_r;
  assign q_instr    = instr_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC ownership, redirect/stall/flush handling, misaligned-target halt.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  fetch_state_t     state_r, state_nxt_s;
  logic [WIDTH-1:0] pc_r, pc_nxt_s, pc_plus4_s;
  logic             fault_r, fault_nxt_s;
  logic [WIDTH-1:0] fault_pc_r, fault_pc_nxt_s;
  logic             load_s, bubble_s, target_aligned_s;

  assign pc_plus4_s       = pc_r + WIDTH'(4);
  assign target_aligned_s = (bus.redirect_pc_in[1:0] == 2'b00);

  // State, PC and fault registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_BOOT;
      pc_r       <= RESET_PC;
      fault_r    <= 1'b0;
      fault_pc_r <= {WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      fault_r    <= fault_nxt_s;
      fault_pc_r <= fault_pc_nxt_s;
    end
  end

  // Next-state, next-PC and IF/ID control; redirect outranks flush, flush outranks stall
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    fault_nxt_s    = fault_r;
    fault_pc_nxt_s = fault_pc_r;
    load_s         = 1'b0;
    bubble_s       = 1'b0;
    case (state_r)
      S_BOOT, S_RUN: begin
        if (bus.redirect_valid_in) begin
          bubble_s = 1'b1;
          if (target_aligned_s) begin
            pc_nxt_s    = bus.redirect_pc_in;
            state_nxt_s = S_RUN;
          end else begin
            fault_nxt_s    = 1'b1;
            fault_pc_nxt_s = bus.redirect_pc_in;
            state_nxt_s    = S_FAULT;
          end
        end else if (state_r == S_BOOT) begin
          bubble_s    = 1'b1;
          state_nxt_s = S_RUN;
        end else if (bus.flush_in) begin
          bubble_s = 1'b1;
          if (bus.stall_in) begin
            pc_nxt_s = pc_r;
          end else begin
            pc_nxt_s = pc_plus4_s;
          end
        end else if (bus.stall_in) begin
          load_s = 1'b0;
        end else begin
          load_s   = 1'b1;
          pc_nxt_s = pc_plus4_s;
        end
      end
      S_FAULT: begin
        bubble_s = 1'b1;
        if (bus.redirect_valid_in) begin
          if (target_aligned_s) begin
            pc_nxt_s       = bus.redirect_pc_in;
            fault_nxt_s    = 1'b0;
            fault_pc_nxt_s = {WIDTH{1'b0}};
            state_nxt_s    = S_RUN;
          end else begin
            fault_pc_nxt_s = bus.redirect_pc_in;
          end
        end else begin
          state_nxt_s = S_FAULT;
        end
      end
      default: begin
        bubble_s    = 1'b1;
        state_nxt_s = S_BOOT;
      end
    endcase
  end

  if_id_reg #(.WIDTH(WIDTH)) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .bubble     (bubble_s),
    .d_pc       (pc_r),
    .d_pc_plus4 (pc_plus4_s),
    .d_instr    (bus.imem_data_in),
    .q_valid    (bus.if_id_valid_out),
    .q_pc       (bus.if_id_pc_out),
    .q_pc_plus4 (bus.if_id_pc_plus4_out),
    .q_instr    (bus.if_id_instr_out)
  );

  assign bus.imem_addr_out = pc_r[WIDTH-1:2];
  assign bus.fault_out     = fault_r;
  assign bus.fault_pc_out  = fault_pc_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_stage_if #(.WIDTH(32)) bus ();

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  function automatic logic [31:0] mem_word(input logic [29:0] waddr);
    if (waddr == 30'd0)      return 32'h0050_0093;
    else if (waddr == 30'd1) return 32'h00A0_0113;
    else                     return ({2'b00, waddr} * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.imem_data_in = mem_word(bus.imem_addr_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural view of fetch (PC, halted/booting flags, IF/ID contents)
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_fpc;
  logic        m_boot, m_halt, m_valid, m_fault;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_bubble();
    m_valid = 1'b0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_instr = NOP;
  endtask

  task automatic model_edge(input logic r, input logic st, input logic fl,
                            input logic rv, input logic [31:0] rpc);
    if (r) begin
      m_pc = 32'd0; m_boot = 1'b1; m_halt = 1'b0; m_fault = 1'b0; m_fpc = 32'd0;
      m_bubble();
    end else if (m_halt) begin
      m_bubble();
      if (rv && (rpc % 32'd4 == 32'd0)) begin
        m_pc = rpc; m_halt = 1'b0; m_fault = 1'b0; m_fpc = 32'd0;
      end else if (rv) begin
        m_fpc = rpc;
      end
    end else begin
      if (rv && (rpc % 32'd4 == 32'd0)) begin
        m_pc = rpc; m_bubble();
      end else if (rv) begin
        m_bubble(); m_fault = 1'b1; m_fpc = rpc; m_halt = 1'b1;
      end else if (m_boot) begin
        m_bubble();
      end else if (fl) begin
        m_bubble();
        if (!st) m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_valid = 1'b1; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_instr = mem_word(m_pc[31:2]);
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check_val({tag, ".addr"},  {34'd0, bus.imem_addr_out}, {34'd0, m_pc[31:2]});
    check_val({tag, ".valid"}, {63'd0, bus.if_id_valid_out}, {63'd0, m_valid});
    check_val({tag, ".pc"},    {32'd0, bus.if_id_pc_out}, {32'd0, m_ipc});
    check_val({tag, ".pc4"},   {32'd0, bus.if_id_pc_plus4_out}, {32'd0, m_ipc4});
    check_val({tag, ".instr"}, {32'd0, bus.if_id_instr_out}, {32'd0, m_instr});
    check_val({tag, ".fault"}, {63'd0, bus.fault_out}, {63'd0, m_fault});
    check_val({tag, ".fpc"},   {32'd0, bus.fault_pc_out}, {32'd0, m_fpc});
  endtask

  task automatic cycle(input string tag, input logic r, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc);
    rst = r; bus.stall_in = st; bus.flush_in = fl;
    bus.redirect_valid_in = rv; bus.redirect_pc_in = rpc;
    @(posedge clk);
    model_edge(r, st, fl, rv, rpc);
    #1;
    compare_all(tag);
  endtask

  initial begin
    logic [31:0] r32;
    logic [1:0]  lo;
    logic        rr, st, fl, rv;
    logic [31:0] rpc;
    checks = 0; failures = 0;
    rst = 1'b1; bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    bus.redirect_valid_in = 1'b0; bus.redirect_pc_in = 32'd0;

    // Reset, boot bubble, free-run of the two-instruction program
    cycle("reset", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("reset.instr_nop", {32'd0, bus.if_id_instr_out}, {32'd0, NOP});
    cycle("boot", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("boot.addr0", {34'd0, bus.imem_addr_out}, 64'd0);
    cycle("run0", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("run0.instr", {32'd0, bus.if_id_instr_out}, 64'h0050_0093);
    check_val("run0.addr1", {34'd0, bus.imem_addr_out}, 64'd1);
    cycle("run1", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("run1.instr", {32'd0, bus.if_id_instr_out}, 64'h00A0_0113);
    check_val("run1.pc", {32'd0, bus.if_id_pc_out}, 64'd4);

    // Stall three cycles at pc=8, then resume
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      check_val("stall.addr2", {34'd0, bus.imem_addr_out}, 64'd2);
    end
    cycle("unstall", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("unstall.pc8", {32'd0, bus.if_id_pc_out}, 64'd8);

    // Redirect overrides stall and flush
    cycle("redir40", 1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    check_val("redir40.addr", {34'd0, bus.imem_addr_out}, 64'h10);
    cycle("redir40b", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("redir40b.pc4", {32'd0, bus.if_id_pc_plus4_out}, 64'h44);

    // Flush alone at pc=0x10
    cycle("redir10", 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    cycle("flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_val("flush.valid", {63'd0, bus.if_id_valid_out}, 64'd0);
    cycle("postflush", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("postflush.pc14", {32'd0, bus.if_id_pc_out}, 64'h14);

    // Misaligned redirect, halt despite stall/flush, aligned exit
    cycle("mis22", 1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
    check_val("mis22.fpc", {32'd0, bus.fault_pc_out}, 64'h22);
    for (int i = 0; i < 5; i++) begin
      cycle("halted", 1'b0, 1'(i % 2), 1'((i + 1) % 2), 1'b0, 32'd0);
      check_val("halted.fault", {63'd0, bus.fault_out}, 64'd1);
    end
    cycle("exit100", 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    check_val("exit100.fault", {63'd0, bus.fault_out}, 64'd0);
    cycle("exit100b", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("exit100b.pc", {32'd0, bus.if_id_pc_out}, 64'h100);

    // Reset while halted with a redirect pending
    cycle("mis2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h103);
    cycle("rsthalt", 1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
    check_val("rsthalt.addr", {34'd0, bus.imem_addr_out}, 64'd0);
    check_val("rsthalt.fault", {63'd0, bus.fault_out}, 64'd0);
    cycle("boot2", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

    // PC wrap at the top of the address space
    cycle("wrapredir", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_val("wrap.pc4", {32'd0, bus.if_id_pc_plus4_out}, 64'd0);
    check_val("wrap.addr", {34'd0, bus.imem_addr_out}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rr  = ($urandom_range(63, 0) == 0);
      st  = ($urandom_range(3, 0) == 0);
      fl  = ($urandom_range(5, 0) == 0);
      rv  = ($urandom_range(7, 0) == 0);
      r32 = $urandom();
      if ($urandom_range(3, 0) == 0) begin
        lo  = 2'($urandom_range(3, 1));
        rpc = {r32[31:2], lo};
      end else if ($urandom_range(7, 0) == 0) begin
        rpc = 32'hFFFF_FFF0 | {28'd0, r32[3:2], 2'b00};
      end else begin
        rpc = {r32[31:2], 2'b00};
      end
      cycle("rand", rr, st, fl, rv, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined core.
- Owns the PC and drives the word-aligned address into the instruction memory. That memory is a combinational read: the instruction returns in the same cycle.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream stages. Halts on a misaligned redirect target.

Parameters:
- WIDTH, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- stall_in  input  1  hazard unit: hold PC and IF/ID.
- flush_in  input  1  squash IF/ID contents (insert bubble).
- redirect_valid_in  input  1  branch/jump taken; load redirect_pc_in.
- redirect_pc_in  input  WIDTH  redirect target byte address.
- imem_addr_out  output  WIDTH-2  word address to instruction memory; equals pc[WIDTH-1:2].
- imem_data_in  input  WIDTH  instruction word from instruction memory, same cycle.
- if_id_valid_out  output  1  IF/ID holds a real instruction.
- if_id_pc_out  output  WIDTH  PC of the IF/ID instruction.
- if_id_pc_plus4_out  output  WIDTH  if_id_pc_out + 4.
- if_id_instr_out  output  WIDTH  instruction word; NOP when not valid.
- fault_out  output  1  high while halted on a misaligned fetch target.
- fault_pc_out  output  WIDTH  offending target address; 0 when no fault.

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_PC; state <= S_BOOT.
  - if_id_valid_out=0, if_id_pc_out=0, if_id_pc_plus4_out=0, if_id_instr_out=NOP (32'h00000013).
  - fault_out=0, fault_pc_out=0.
  - Reset mid-operation discards all state, including a pending redirect.
- imem_addr_out is combinational from the pc register in every state.
- States:
  - S_BOOT: one cycle after reset deassert; IF/ID stays a bubble; pc held; -> S_RUN unconditionally, unless redirect_valid_in, which is handled as in S_RUN.
  - S_RUN: normal fetch.
  - S_FAULT: fetch halted.
- S_RUN per-edge priority, highest first:
  1. Redirect, target aligned (redirect_pc_in[1:0]==0): pc <= redirect_pc_in; IF/ID <= bubble. Overrides stall_in and flush_in.
  2. Redirect, target misaligned: pc held; IF/ID <= bubble; fault_pc_out <= redirect_pc_in; fault_out <= 1; -> S_FAULT.
  3. flush_in=1, no redirect: IF/ID <= bubble. pc advances by 4 unless stall_in=1, in which case pc is held.
  4. stall_in=1: pc and IF/ID hold their values.
  5. Otherwise: IF/ID <= {valid=1, pc, pc+4, imem_data_in}; pc <= pc+4.
- S_FAULT:
  - IF/ID held as bubble; pc held; stall_in and flush_in ignored.
  - Only an aligned redirect exits: pc <= target; fault_out <= 0; fault_pc_out <= 0; -> S_RUN. The first valid instruction appears in IF/ID one edge later.
  - A further misaligned redirect updates fault_pc_out; state stays S_FAULT.
- Latency: instruction at address A is visible on if_id_* one edge after pc==A with no stall. Redirect-to-first-valid-IF/ID is 2 edges.
- Arithmetic: pc+4 is modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 0 with no fault. The PC is never misaligned internally.
- Bubble definition: valid=0, instr=NOP, pc=0, pc_plus4=0.

Decomposition:
- Shared defs package:
  - NOP_INSTR constant 32'h00000013, reused by the instruction memory's static fill.
  - fetch_state_t enum {S_BOOT, S_RUN, S_FAULT}.
  - if_id_t packed struct {valid, pc, pc_plus4, instr}, reused by the decode stage.
- One sub-module: if_id_reg, a pipeline register with load/hold/bubble controls, instantiated here. PC update logic and the FSM stay in fetch_stage.

Test Plan:
- Reset then free-run, program at RESET_PC=0 holding 0x00500093, 0x00A00113 -> S_BOOT bubble for one cycle; IF/ID shows pc=0/instr=0x00500093, then pc=4/instr=0x00A00113; imem_addr_out 0,1,2.
- stall_in high for 3 cycles at pc=8 -> imem_addr_out stays 2; if_id_* unchanged for 3 cycles; pc=8 enters IF/ID on the first unstalled edge.
- redirect_valid_in=1 to 0x40 together with stall_in=1 and flush_in=1 -> next edge pc=0x40 and IF/ID bubble (NOP, valid=0); following edge IF/ID pc=0x40, pc_plus4=0x44.
- flush_in=1 alone at pc=0x10 -> IF/ID bubble; pc=0x14 next cycle; the instruction at 0x10 is never valid in IF/ID.
- Misaligned redirect to 0x22 -> fault_out=1, fault_pc_out=0x22, IF/ID bubble held for 5 cycles despite stall/flush toggling. Aligned redirect to 0x100 -> fault_out=0; IF/ID valid pc=0x100 two edges later.
- rst asserted while in S_FAULT with a redirect present -> all outputs at reset values; pc=RESET_PC; the redirect is ignored.
